vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA mode controller: validates mode requests and reloads the timing generator at end of frame.
// The pixel path is blanked across the reload and for SETTLE_FRAMES frame ends after it.
module vga_timing_ctrl #(
    parameter int unsigned H_W           = 11,
    parameter int unsigned V_W           = 10,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mode_valid_i,
    output logic             mode_ready_o,
    input  logic [1:0]       mode_sel_i,
    input  logic [4*H_W-1:0] cust_h_i,
    input  logic [4*V_W-1:0] cust_v_i,
    input  logic [H_W-1:0]   hcount_i,
    input  logic [V_W-1:0]   vcount_i,
    output logic             tg_we_o,
    output logic [4*H_W-1:0] tg_h_o,
    output logic [4*V_W-1:0] tg_v_o,
    output logic             blank_o,
    output logic             busy_o,
    output logic             err_o,
    input  logic             err_clr_i,
    output logic [1:0]       cur_mode_o
);

    localparam int unsigned HS_W = H_W + 2;
    localparam int unsigned VS_W = V_W + 2;
    localparam logic [4*H_W-1:0] MODE0_H = {H_W'(640), H_W'(16), H_W'(96), H_W'(48)};
    localparam logic [4*V_W-1:0] MODE0_V = {V_W'(480), V_W'(10), V_W'(2), V_W'(33)};
    localparam logic [H_W-1:0]   MODE0_HTOT  = H_W'(800);
    localparam logic [V_W-1:0]   MODE0_VTOT  = V_W'(525);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_CHECK,
        S_WAIT_EOF,
        S_SETTLE
    } state_t;

    state_t           r_state;
    logic [1:0]       r_pend_sel;
    logic [1:0]       r_cur_mode;
    logic [4*H_W-1:0] r_pend_h;
    logic [4*V_W-1:0] r_pend_v;
    logic [4*H_W-1:0] r_tg_h;
    logic [4*V_W-1:0] r_tg_v;
    logic [H_W-1:0]   r_htot;
    logic [V_W-1:0]   r_vtot;
    logic [3:0]       r_settle_cnt;
    logic             r_ready;
    logic             r_blank;
    logic             r_busy;
    logic             r_err;

    function automatic logic [4*H_W-1:0] preset_h(input logic [1:0] sel);
        case (sel)
            2'd1:    preset_h = {H_W'(800), H_W'(40), H_W'(128), H_W'(88)};
            2'd2:    preset_h = {H_W'(1024), H_W'(24), H_W'(136), H_W'(160)};
            default: preset_h = MODE0_H;
        endcase
    endfunction

    function automatic logic [4*V_W-1:0] preset_v(input logic [1:0] sel);
        case (sel)
            2'd1:    preset_v = {V_W'(600), V_W'(1), V_W'(4), V_W'(23)};
            2'd2:    preset_v = {V_W'(768), V_W'(3), V_W'(6), V_W'(29)};
            default: preset_v = MODE0_V;
        endcase
    endfunction

    // Pending-set validation; sums carry two guard bits to detect overflow
    logic [H_W-1:0]  w_hd, w_hf, w_hr, w_hb;
    logic [V_W-1:0]  w_vd, w_vf, w_vr, w_vb;
    logic [HS_W-1:0] w_hsum;
    logic [VS_W-1:0] w_vsum;
    logic            w_h_ok;
    logic            w_v_ok;
    logic            w_eof;
    logic            w_reload;

    assign {w_hd, w_hf, w_hr, w_hb} = r_pend_h;
    assign {w_vd, w_vf, w_vr, w_vb} = r_pend_v;
    assign w_hsum = HS_W'(w_hd) + HS_W'(w_hf) + HS_W'(w_hr) + HS_W'(w_hb);
    assign w_vsum = VS_W'(w_vd) + VS_W'(w_vf) + VS_W'(w_vr) + VS_W'(w_vb);

    assign w_h_ok = (w_hd != '0) && (w_hf != '0) && (w_hr != '0) && (w_hb != '0) &&
                    (w_hd > w_hf) && (w_hd > w_hr) && (w_hd > w_hb) &&
                    (w_hsum[HS_W-1:H_W] == '0);
    assign w_v_ok = (w_vd != '0) && (w_vf != '0) && (w_vr != '0) && (w_vb != '0) &&
                    (w_vd > w_vf) && (w_vd > w_vr) && (w_vd > w_vb) &&
                    (w_vsum[VS_W-1:V_W] == '0);

    assign w_eof    = (hcount_i == r_htot - H_W'(1)) && (vcount_i == r_vtot - V_W'(1));
    assign w_reload = (r_pend_sel == 2'd3) || (r_pend_sel != r_cur_mode);

    // Write strobe must coincide with the frame-end edge, so it is decoded from the live counters
    assign tg_we_o = !rst_i && ((r_state == S_BOOT) || ((r_state == S_WAIT_EOF) && w_eof));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_BOOT;
            r_pend_sel   <= 2'd0;
            r_cur_mode   <= 2'd0;
            r_pend_h     <= MODE0_H;
            r_pend_v     <= MODE0_V;
            r_tg_h       <= MODE0_H;
            r_tg_v       <= MODE0_V;
            r_htot       <= MODE0_HTOT;
            r_vtot       <= MODE0_VTOT;
            r_settle_cnt <= 4'd0;
            r_ready      <= 1'b0;
            r_blank      <= 1'b1;
            r_busy       <= 1'b1;
            r_err        <= 1'b0;
        end else begin
            if (err_clr_i) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_BOOT: begin
                    r_htot       <= MODE0_HTOT;
                    r_vtot       <= MODE0_VTOT;
                    r_cur_mode   <= 2'd0;
                    r_settle_cnt <= 4'd0;
                    r_state      <= S_SETTLE;
                end
                S_IDLE: begin
                    if (mode_valid_i && r_ready) begin
                        r_pend_sel <= mode_sel_i;
                        r_pend_h   <= (mode_sel_i == 2'd3) ? cust_h_i : preset_h(mode_sel_i);
                        r_pend_v   <= (mode_sel_i == 2'd3) ? cust_v_i : preset_v(mode_sel_i);
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!(w_h_ok && w_v_ok)) begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!w_reload) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tg_h  <= r_pend_h;
                        r_tg_v  <= r_pend_v;
                        r_blank <= 1'b1;
                        r_state <= S_WAIT_EOF;
                    end
                end
                S_WAIT_EOF: begin
                    if (w_eof) begin
                        r_htot       <= w_hsum[H_W-1:0];
                        r_vtot       <= w_vsum[V_W-1:0];
                        r_cur_mode   <= r_pend_sel;
                        r_settle_cnt <= 4'd0;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_eof) begin
                        if (r_settle_cnt == SETTLE_LAST) begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_blank <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign mode_ready_o = r_ready;
    assign tg_h_o       = r_tg_h;
    assign tg_v_o       = r_tg_v;
    assign blank_o      = r_blank;
    assign busy_o       = r_busy;
    assign err_o        = r_err;
    assign cur_mode_o   = r_cur_mode;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: directed frame-end vectors, a transaction-level model checked
// every cycle, and literal expectations for the key timing points.
module tb_vga_timing_ctrl;

    localparam int HW = 11;
    localparam int VW = 10;
    localparam int SETTLE = 2;

    logic          clk;
    logic          rst;
    logic          mode_valid;
    logic          mode_ready;
    logic [1:0]    mode_sel;
    logic [4*HW-1:0] cust_h;
    logic [4*VW-1:0] cust_v;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          tg_we;
    logic [4*HW-1:0] tg_h;
    logic [4*VW-1:0] tg_v;
    logic          blank;
    logic          busy;
    logic          err;
    logic          err_clr;
    logic [1:0]    cur_mode;

    vga_timing_ctrl #(.H_W(HW), .V_W(VW), .SETTLE_FRAMES(SETTLE)) dut (
        .clk_i(clk), .rst_i(rst), .mode_valid_i(mode_valid), .mode_ready_o(mode_ready),
        .mode_sel_i(mode_sel), .cust_h_i(cust_h), .cust_v_i(cust_v),
        .hcount_i(hcount), .vcount_i(vcount), .tg_we_o(tg_we), .tg_h_o(tg_h), .tg_v_o(tg_v),
        .blank_o(blank), .busy_o(busy), .err_o(err), .err_clr_i(err_clr), .cur_mode_o(cur_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Preset table as plain numbers, fields in {display, front, sync, back} order
    int PH [3][4] = '{'{640, 16, 96, 48}, '{800, 40, 128, 88}, '{1024, 24, 136, 160}};
    int PV [3][4] = '{'{480, 10, 2, 33},  '{600, 1, 4, 23},    '{768, 3, 6, 29}};

    function automatic int sum4(input int f[4]);
        return f[0] + f[1] + f[2] + f[3];
    endfunction

    function automatic bit fields_ok(input int f[4], input int w);
        return f[1] > 0 && f[2] > 0 && f[3] > 0 && f[0] > f[1] && f[0] > f[2] &&
               f[0] > f[3] && sum4(f) < (1 << w);
    endfunction

    function automatic logic [63:0] pack_h(input int f[4]);
        return 64'({HW'(f[0]), HW'(f[1]), HW'(f[2]), HW'(f[3])});
    endfunction

    function automatic logic [63:0] pack_v(input int f[4]);
        return 64'({VW'(f[0]), VW'(f[1]), VW'(f[2]), VW'(f[3])});
    endfunction

    // Model: which phase of a mode change we are in, plus the loaded and pending timings
    bit m_on = 0, m_boot, m_check, m_wait, m_err, m_eof;
    int m_settle, m_cur, m_ht, m_vt, p_sel;
    int p_h[4], p_v[4], t_h[4], t_v[4];

    function automatic bit model_eof();
        return int'(hcount) == m_ht - 1 && int'(vcount) == m_vt - 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1; m_boot = 1; m_check = 0; m_wait = 0; m_settle = 0; m_err = 0;
            m_cur = 0; m_ht = 800; m_vt = 525; t_h = PH[0]; t_v = PV[0];
        end else if (m_on) begin
            m_eof = model_eof();
            if (err_clr) m_err = 0;
            if (m_boot) begin
                m_boot = 0; m_settle = SETTLE;
            end else if (m_wait) begin
                if (m_eof) begin
                    m_ht = sum4(t_h); m_vt = sum4(t_v); m_cur = p_sel;
                    m_wait = 0; m_settle = SETTLE;
                end
            end else if (m_settle > 0) begin
                if (m_eof) m_settle--;
            end else if (m_check) begin
                m_check = 0;
                if (!(fields_ok(p_h, HW) && fields_ok(p_v, VW))) m_err = 1;
                else if (p_sel == 3 || p_sel != m_cur) begin
                    m_wait = 1; t_h = p_h; t_v = p_v;
                end
            end else if (mode_valid) begin
                p_sel = int'(mode_sel);
                if (p_sel == 3) begin
                    for (int k = 0; k < 4; k++) begin
                        p_h[k] = int'(cust_h[(3-k)*HW +: HW]);
                        p_v[k] = int'(cust_v[(3-k)*VW +: VW]);
                    end
                end else begin
                    p_h = PH[p_sel]; p_v = PV[p_sel];
                end
                m_check = 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_on) begin
            bit e_ready;
            e_ready = !m_boot && !m_wait && !m_check && m_settle == 0;
            check("ready", 64'(mode_ready), 64'(e_ready));
            check("busy", 64'(busy), 64'(!e_ready));
            check("blank", 64'(blank), 64'(m_boot || m_wait || m_settle > 0));
            check("we", 64'(tg_we), 64'(!rst && (m_boot || (m_wait && model_eof()))));
            check("tg_h", 64'(tg_h), pack_h(t_h));
            check("tg_v", 64'(tg_v), pack_v(t_v));
            check("cur_mode", 64'(cur_mode), 64'(m_cur));
            check("err", 64'(err), 64'(m_err));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic eof_at(input int h, input int v);
        hcount = HW'(h); vcount = VW'(v);
        tick();
        hcount = '0; vcount = '0;
    endtask

    task automatic request(input logic [1:0] sel);
        mode_sel = sel; mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
    endtask

    localparam logic [4*HW-1:0] LIT_H0 = {11'd640, 11'd16, 11'd96, 11'd48};
    localparam logic [4*VW-1:0] LIT_V0 = {10'd480, 10'd10, 10'd2, 10'd33};
    localparam logic [4*HW-1:0] LIT_H2 = {11'd1024, 11'd24, 11'd136, 11'd160};
    localparam logic [4*VW-1:0] LIT_V2 = {10'd768, 10'd3, 10'd6, 10'd29};

    logic [4*HW-1:0] bad_h [3];

    initial begin
        rst = 1'b1; mode_valid = 1'b0; mode_sel = 2'd0; cust_h = '0; cust_v = '0;
        hcount = '0; vcount = '0; err_clr = 1'b0;
        tick(3);
        rst = 1'b0;

        // Boot write and settle over two mode-0 frame ends
        @(negedge clk);
        check("boot_we", 64'(tg_we), 64'd1);
        check("boot_tg_h", 64'(tg_h), 64'(LIT_H0));
        check("boot_tg_v", 64'(tg_v), 64'(LIT_V0));
        tick();
        @(negedge clk);
        check("boot_we_once", 64'(tg_we), 64'd0);
        eof_at(799, 524);
        tick(3);
        @(negedge clk);
        check("boot_ready_1eof", 64'(mode_ready), 64'd0);
        eof_at(799, 524);
        @(negedge clk);
        check("boot_ready_2eof", 64'(mode_ready), 64'd1);
        check("boot_blank_off", 64'(blank), 64'd0);

        // Mode 2 requested mid-frame, written only at the mode-0 frame end
        hcount = 11'd100; vcount = 10'd10;
        request(2'd2);
        @(negedge clk);
        check("m2_check_busy", 64'(busy), 64'd1);
        tick();
        hcount = 11'd799; vcount = 10'd10;
        tick(2);
        hcount = 11'd100; vcount = 10'd524;
        tick();
        hcount = 11'd799; vcount = 10'd524;
        @(negedge clk);
        check("m2_we", 64'(tg_we), 64'd1);
        check("m2_tg_h", 64'(tg_h), 64'(LIT_H2));
        check("m2_tg_v", 64'(tg_v), 64'(LIT_V2));
        tick();
        hcount = '0; vcount = '0;
        @(negedge clk);
        check("m2_cur", 64'(cur_mode), 64'd2);
        eof_at(799, 524);
        eof_at(1343, 805);
        @(negedge clk);
        check("m2_settle_1eof", 64'(mode_ready), 64'd0);
        eof_at(1343, 805);
        @(negedge clk);
        check("m2_ready", 64'(mode_ready), 64'd1);

        // Rejected custom sets: hd == hf, zero field, horizontal sum overflow
        cust_v = {10'd50, 10'd2, 10'd3, 10'd4};
        bad_h[0] = {11'd10, 11'd10, 11'd5, 11'd5};
        bad_h[1] = {11'd100, 11'd10, 11'd20, 11'd0};
        bad_h[2] = {11'd2000, 11'd20, 11'd20, 11'd20};
        for (int i = 0; i < 3; i++) begin
            cust_h = bad_h[i];
            request(2'd3);
            if (i == 2) err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            @(negedge clk);
            check("bad_err_set", 64'(err), 64'd1);
            check("bad_cur_kept", 64'(cur_mode), 64'd2);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            @(negedge clk);
            check("bad_err_clr", 64'(err), 64'd0);
        end

        // Valid custom set loads; the same custom set again is still reloaded
        cust_h = {11'd100, 11'd10, 11'd20, 11'd30};
        for (int i = 0; i < 2; i++) begin
            request(2'd3);
            tick();
            @(negedge clk);
            check("cust_wait_blank", 64'(blank), 64'd1);
            eof_at(i == 0 ? 1343 : 159, i == 0 ? 805 : 58);
            eof_at(159, 58);
            eof_at(159, 58);
            @(negedge clk);
            check("cust_cur", 64'(cur_mode), 64'd3);
            check("cust_ready", 64'(mode_ready), 64'd1);
        end

        // Back to mode 0, then a redundant mode-0 request
        request(2'd0);
        tick();
        eof_at(159, 58);
        eof_at(799, 524);
        eof_at(799, 524);
        request(2'd0);
        @(negedge clk);
        check("same_busy", 64'(busy), 64'd1);
        check("same_blank", 64'(blank), 64'd0);
        tick();
        @(negedge clk);
        check("same_idle", 64'(busy), 64'd0);

        // Request held through SETTLE transfers on the first IDLE cycle
        request(2'd1);
        tick();
        eof_at(799, 524);
        mode_sel = 2'd2; mode_valid = 1'b1;
        tick(2);
        eof_at(1055, 627);
        eof_at(1055, 627);
        @(negedge clk);
        check("held_ready", 64'(mode_ready), 64'd1);
        tick();
        mode_valid = 1'b0;
        @(negedge clk);
        check("held_transfer", 64'(busy), 64'd1);
        tick();

        // Reset while waiting for frame end discards the pending mode
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_boot_we", 64'(tg_we), 64'd1);
        check("rst_tg_h", 64'(tg_h), 64'(LIT_H0));
        tick();
        eof_at(1055, 627);
        @(negedge clk);
        check("rst_cur0", 64'(cur_mode), 64'd0);
        eof_at(799, 524);
        eof_at(799, 524);
        @(negedge clk);
        check("rst_ready", 64'(mode_ready), 64'd1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
